// File: rtl/fifo_ctrl_if.sv
// Stream and RAM-port bundle for fifo_ctrl.
// The slave modport is the controller's view; the master modport is the
// environment that produces writes, consumes the head word and models the RAM.
interface fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) ();

  // Write side
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;

  // Read side
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  // External RAM ports
  logic                  ram_w_en;
  logic [ADDR_WIDTH-1:0] ram_w_addr;
  logic [DATA_WIDTH-1:0] ram_w_data;
  logic                  ram_r_en;
  logic [ADDR_WIDTH-1:0] ram_r_addr;
  logic [DATA_WIDTH-1:0] ram_r_data;

  modport slave (
    input  s_valid, s_data, m_ready, ram_r_data,
    output s_ready, m_valid, m_data,
    output ram_w_en, ram_w_addr, ram_w_data,
    output ram_r_en, ram_r_addr
  );

  modport master (
    output s_valid, s_data, m_ready, ram_r_data,
    input  s_ready, m_valid, m_data,
    input  ram_w_en, ram_w_addr, ram_w_data,
    input  ram_r_en, ram_r_addr
  );

endinterface

// File: rtl/fifo_ctrl.sv
// FIFO controller in front of an external RAM with a registered read port.
// The head word is prefetched into the output stage (m_valid), so total
// occupancy is the RAM word count plus one when the head is valid.
// The RAM read register is the output data holder: it only loads when
// ram_r_en is high, which keeps m_data stable while the consumer stalls.
module fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  fifo_ctrl_if.slave          bus,
  output logic [ADDR_WIDTH:0] count,
  output logic                full,
  output logic                empty
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(RAM_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  m_valid_q, m_valid_d;

  logic clear;
  logic push;
  logic issue;

  // Reset and flush both wipe the state and block any handshake in that cycle.
  assign clear = rst | flush;

  assign full        = (ram_cnt_q == CNT_FULL);
  assign count       = ram_cnt_q + {{ADDR_WIDTH{1'b0}}, m_valid_q};
  assign empty       = (count == CNT_ZERO);

  assign bus.s_ready = ~full & ~clear;
  assign push        = bus.s_valid & bus.s_ready;

  // A read is issued only from words already counted in the RAM, which
  // guarantees a word written this cycle is never read at the same address.
  assign issue       = (ram_cnt_q != CNT_ZERO) & (~m_valid_q | bus.m_ready) & ~clear;

  assign bus.ram_w_en   = push;
  assign bus.ram_w_addr = wr_ptr_q;
  assign bus.ram_w_data = bus.s_data;

  assign bus.ram_r_en   = issue;
  assign bus.ram_r_addr = rd_ptr_q;

  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = bus.ram_r_data;

  // Next-state for pointers, RAM word count and the output-valid stage.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    m_valid_d = m_valid_q;

    if (push) begin
      if (wr_ptr_q == PTR_LAST) begin
        wr_ptr_d = PTR_ZERO;
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (issue) begin
      if (rd_ptr_q == PTR_LAST) begin
        rd_ptr_d = PTR_ZERO;
      end else begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push && !issue) begin
      ram_cnt_d = ram_cnt_q + CNT_ONE;
    end else if (!push && issue) begin
      ram_cnt_d = ram_cnt_q - CNT_ONE;
    end else begin
      ram_cnt_d = ram_cnt_q;
    end

    // A read issued this cycle lands in the read register at the edge, so the
    // head becomes valid; that takes priority over a pop of the old head.
    if (issue) begin
      m_valid_d = 1'b1;
    end else if (m_valid_q && bus.m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // State registers; reset and flush clear everything, discarding in-flight reads.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q  <= PTR_ZERO;
      rd_ptr_q  <= PTR_ZERO;
      ram_cnt_q <= CNT_ZERO;
      m_valid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      m_valid_q <= m_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a directed vector table for the basic
// cycle-by-cycle behaviour, plus hand-written sequences for fill, stall,
// streaming with pointer wrap, and flush/reset with a read pending.
module tb_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NV    = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q[$];
  logic [AW-1:0] exp_wp;

  fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_ctrl #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read that holds when not enabled.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_w_en) mem[bus.ram_w_addr] <= bus.ram_w_data;
    if (bus.ram_r_en) bus.ram_r_data <= mem[bus.ram_r_addr];
  end

  typedef struct {
    logic          rst;
    logic          flush;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          m_ready;
    logic          e_s_ready;
    logic          e_w_en;
    logic [AW-1:0] e_w_addr;
    logic          e_r_en;
    logic [AW-1:0] e_r_addr;
    logic          e_m_valid;
    logic [DW-1:0] e_m_data;
    logic [AW:0]   e_count;
    logic          e_empty;
    logic          e_full;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    next_cycle();
    rst = 1'b0;
    exp_wp = '0;
    q.delete();
  endtask

  // Fill to count 9, then clear (flush or reset) in a cycle that would issue a read.
  task automatic clear_case(input bit use_rst, input string nm);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(8'h10 + i);
      next_cycle();
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_pre_count"}, 32'(count), 32'd9);
    next_cycle();
    bus.m_ready = 1'b1;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    chk({nm, "_clr_r_en"}, 32'(bus.ram_r_en), 32'd0);
    chk({nm, "_clr_s_ready"}, 32'(bus.s_ready), 32'd0);
    next_cycle();
    rst = 1'b0;
    flush = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hD7;
    @(negedge clk);
    chk({nm, "_post_count"}, 32'(count), 32'd0);
    chk({nm, "_post_m_valid"}, 32'(bus.m_valid), 32'd0);
    chk({nm, "_post_w_en"}, 32'(bus.ram_w_en), 32'd1);
    chk({nm, "_post_w_addr"}, 32'(bus.ram_w_addr), 32'd0);
    next_cycle();
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_n1_r_en"}, 32'(bus.ram_r_en), 32'd1);
    chk({nm, "_n1_m_valid"}, 32'(bus.m_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk({nm, "_n2_m_valid"}, 32'(bus.m_valid), 32'd1);
    chk({nm, "_n2_m_data"}, 32'(bus.m_data), 32'hD7);
    next_cycle();
    bus.m_ready = 1'b0;
  endtask

  initial begin
    //           rst  fl   sv   data   mr   | srdy wen  wa   ren  ra   mv   mdata  cnt  emp  full
    vecs[0]  = '{1'b1,1'b0,1'b1,8'h11,1'b1, 1'b0,1'b0,4'd0,1'b0,4'd0,1'b0,8'h00,5'd0,1'b1,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,4'd0,1'b0,4'd0,1'b0,8'h00,5'd0,1'b1,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b1,8'hA5,1'b1, 1'b1,1'b1,4'd0,1'b0,4'd0,1'b0,8'h00,5'd0,1'b1,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,4'd0,1'b1,4'd0,1'b0,8'h00,5'd1,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,4'd0,1'b0,4'd0,1'b1,8'hA5,5'd1,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,4'd0,1'b0,4'd0,1'b0,8'h00,5'd0,1'b1,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b1,8'h3C,1'b0, 1'b1,1'b1,4'd1,1'b0,4'd0,1'b0,8'h00,5'd0,1'b1,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b1,8'h5A,1'b0, 1'b1,1'b1,4'd2,1'b1,4'd1,1'b0,8'h00,5'd1,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,4'd0,1'b0,4'd0,1'b1,8'h3C,5'd2,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,4'd0,1'b1,4'd2,1'b1,8'h3C,5'd2,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,4'd0,1'b0,4'd0,1'b1,8'h5A,5'd1,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b1,8'h77,1'b0, 1'b1,1'b1,4'd3,1'b0,4'd0,1'b1,8'h5A,5'd1,1'b0,1'b0};
    vecs[12] = '{1'b0,1'b1,1'b1,8'h99,1'b1, 1'b0,1'b0,4'd0,1'b0,4'd0,1'b1,8'h5A,5'd2,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,4'd0,1'b0,4'd0,1'b0,8'h00,5'd0,1'b1,1'b0};
    vecs[14] = '{1'b0,1'b0,1'b1,8'hC3,1'b1, 1'b1,1'b1,4'd0,1'b0,4'd0,1'b0,8'h00,5'd0,1'b1,1'b0};
    vecs[15] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,4'd0,1'b1,4'd0,1'b0,8'h00,5'd1,1'b0,1'b0};
    vecs[16] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,4'd0,1'b0,4'd0,1'b1,8'hC3,5'd1,1'b0,1'b0};

    rst = 1'b1;
    flush = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    exp_wp = '0;
    next_cycle();

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      rst         = vecs[i].rst;
      flush       = vecs[i].flush;
      bus.s_valid = vecs[i].s_valid;
      bus.s_data  = vecs[i].s_data;
      bus.m_ready = vecs[i].m_ready;
      @(negedge clk);
      chk($sformatf("row%0d_s_ready", i), 32'(bus.s_ready), 32'(vecs[i].e_s_ready));
      chk($sformatf("row%0d_w_en", i), 32'(bus.ram_w_en), 32'(vecs[i].e_w_en));
      chk($sformatf("row%0d_r_en", i), 32'(bus.ram_r_en), 32'(vecs[i].e_r_en));
      chk($sformatf("row%0d_m_valid", i), 32'(bus.m_valid), 32'(vecs[i].e_m_valid));
      chk($sformatf("row%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("row%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      chk($sformatf("row%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      if (vecs[i].e_w_en) begin
        chk($sformatf("row%0d_w_addr", i), 32'(bus.ram_w_addr), 32'(vecs[i].e_w_addr));
        chk($sformatf("row%0d_w_data", i), 32'(bus.ram_w_data), 32'(vecs[i].s_data));
      end
      if (vecs[i].e_r_en) begin
        chk($sformatf("row%0d_r_addr", i), 32'(bus.ram_r_addr), 32'(vecs[i].e_r_addr));
      end
      if (vecs[i].e_m_valid) begin
        chk($sformatf("row%0d_m_data", i), 32'(bus.m_data), 32'(vecs[i].e_m_data));
      end
      next_cycle();
    end
    rst = 1'b0;
    flush = 1'b0;

    // Fill: 17 pushes with the consumer stalled -> 16 in RAM plus the head
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(8'h40 + i);
      @(negedge clk);
      chk($sformatf("fill%0d_s_ready", i), 32'(bus.s_ready), 32'd1);
      chk($sformatf("fill%0d_w_addr", i), 32'(bus.ram_w_addr), 32'(exp_wp));
      q.push_back(bus.s_data);
      exp_wp = exp_wp + 4'd1;
      next_cycle();
    end
    bus.s_data = 8'hEE;
    @(negedge clk);
    chk("full_count", 32'(count), 32'd17);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_s_ready", 32'(bus.s_ready), 32'd0);
    chk("full_w_en", 32'(bus.ram_w_en), 32'd0);
    chk("full_head", 32'(bus.m_data), 32'h40);
    next_cycle();
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("full_count_after_ignored_push", 32'(count), 32'd17);
    next_cycle();

    // Stall: head held with m_ready low for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_m_data", i), 32'(bus.m_data), 32'h40);
      chk($sformatf("stall%0d_r_en", i), 32'(bus.ram_r_en), 32'd0);
      chk($sformatf("stall%0d_m_valid", i), 32'(bus.m_valid), 32'd1);
      next_cycle();
    end

    // Pop one so a push can accompany every pop while streaming
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("pop1_r_en", 32'(bus.ram_r_en), 32'd1);
    chk("pop1_m_data", 32'(bus.m_data), 32'(q.pop_front()));
    next_cycle();

    // Stream 40 cycles: pointers wrap twice, occupancy constant at 16
    for (int i = 0; i < 40; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(8'h80 + i);
      bus.m_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("strm%0d_s_ready", i), 32'(bus.s_ready), 32'd1);
      chk($sformatf("strm%0d_w_addr", i), 32'(bus.ram_w_addr), 32'(exp_wp));
      chk($sformatf("strm%0d_r_en", i), 32'(bus.ram_r_en), 32'd1);
      chk($sformatf("strm%0d_count", i), 32'(count), 32'd16);
      chk($sformatf("strm%0d_m_valid", i), 32'(bus.m_valid), 32'd1);
      chk($sformatf("strm%0d_m_data", i), 32'(bus.m_data), 32'(q.pop_front()));
      q.push_back(bus.s_data);
      exp_wp = exp_wp + 4'd1;
      next_cycle();
    end

    // Drain remaining words in order, bounded
    bus.s_valid = 1'b0;
    for (int i = 0; i < 40 && q.size() > 0; i++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        chk($sformatf("drain%0d_m_data", i), 32'(bus.m_data), 32'(q.pop_front()));
      end
      next_cycle();
    end
    chk("drain_left", 32'(q.size()), 32'd0);
    @(negedge clk);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_m_valid", 32'(bus.m_valid), 32'd0);
    next_cycle();
    bus.m_ready = 1'b0;

    // Flush and reset with count 9 and a read about to be issued
    clear_case(1'b0, "flush");
    clear_case(1'b1, "rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the data word.
REQ-002 SHALL have parameter RAM_DEPTH, default 16: number of RAM entries, equal to 2**ADDR_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4: width of the RAM address.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port flush, input, 1 bit: synchronous clear of all contents.
REQ-007 SHALL have port s_valid, input, 1 bit: write request.
REQ-008 SHALL have port s_ready, output, 1 bit: write accept.
REQ-009 SHALL have port s_data, input, DATA_WIDTH bits: write data.
REQ-010 SHALL have port m_valid, output, 1 bit: head word is valid.
REQ-011 SHALL have port m_ready, input, 1 bit: consumer pop.
REQ-012 SHALL have port m_data, output, DATA_WIDTH bits: head word, driven directly from ram_r_data.
REQ-013 SHALL have port ram_w_en, output, 1 bit: RAM write enable.
REQ-014 SHALL have port ram_w_addr, output, ADDR_WIDTH bits: RAM write address.
REQ-015 SHALL have port ram_w_data, output, DATA_WIDTH bits: RAM write data.
REQ-016 SHALL have port ram_r_en, output, 1 bit: RAM read enable.
REQ-017 SHALL have port ram_r_addr, output, ADDR_WIDTH bits: RAM read address.
REQ-018 SHALL have port ram_r_data, input, DATA_WIDTH bits: RAM registered read data, valid 1 cycle after ram_r_en and held while ram_r_en is low.
REQ-019 SHALL have port count, output, ADDR_WIDTH+1 bits: total occupancy, computed as ram_cnt + m_valid.
REQ-020 SHALL have port full, output, 1 bit: asserted when ram_cnt == RAM_DEPTH.
REQ-021 SHALL have port empty, output, 1 bit: asserted when count == 0.

Function
REQ-022 SHALL hold internal state wr_ptr, rd_ptr (ADDR_WIDTH bits each), ram_cnt (ADDR_WIDTH+1 bits) and m_valid.
REQ-023 SHALL drive s_ready = !full && !rst && !flush, combinationally.
REQ-024 SHALL define push = s_valid && s_ready.
REQ-025 SHALL, on push, drive ram_w_en=1, ram_w_addr=wr_ptr, ram_w_data=s_data in the same cycle, and increment wr_ptr modulo RAM_DEPTH (RAM_DEPTH-1 wraps to 0).
REQ-026 SHALL define issue = (ram_cnt != 0) && (!m_valid || m_ready) && !rst && !flush.
REQ-027 SHALL, on issue, drive ram_r_en=1, ram_r_addr=rd_ptr, and increment rd_ptr modulo RAM_DEPTH.
REQ-028 SHALL set m_valid on the edge ending an issue cycle; otherwise SHALL clear m_valid when m_valid && m_ready; otherwise m_valid holds.
REQ-029 SHALL update ram_cnt: +1 on push only, -1 on issue only, unchanged on both or neither.
REQ-030 SHALL base issue on ram_cnt of the current cycle, so a word written in cycle N is readable no earlier than cycle N+1 (no same-address read/write collision).
REQ-031 SHALL give latency: push into an empty block in cycle N -> ram_r_en in N+1 -> m_valid in N+2.
REQ-032 SHALL sustain 1 pop per cycle while ram_cnt > 0 and m_ready=1.
REQ-033 SHALL keep m_data stable while m_valid && !m_ready, since ram_r_en stays low.
REQ-034 SHALL ignore s_valid while full; SHALL hold m_valid=0 and ram_r_en=0 while empty.
REQ-035 SHALL, on flush, behave at the edge exactly as reset; a push or issue in the flush cycle is suppressed.

Reset
REQ-036 SHALL, with rst high at a clk edge, clear wr_ptr, rd_ptr, ram_cnt and m_valid to 0.
REQ-037 SHALL hold s_ready=0, ram_w_en=0 and ram_r_en=0 while rst is high.
REQ-038 SHALL present, after reset, count=0, empty=1, full=0, m_valid=0, s_ready=1.
REQ-039 SHALL not rely on RAM read-register reset; m_data is don't-care while m_valid=0.
REQ-040 SHALL discard in-flight data when reset is asserted mid-operation (an issued read does not set m_valid).

Verification
REQ-041 SHALL cover: push 0xA5 at cycle 0, m_ready=1 -> ram_w_addr=0 at cycle 0, ram_r_en at 1, m_valid=1 and m_data=0xA5 at 2, empty=1 at 3.
REQ-042 SHALL cover: 17 pushes with m_ready=0 -> 16 written to RAM plus 1 prefetched into m_valid, count=17; then full=1, s_ready=0, and a further push is ignored.
REQ-043 SHALL cover: fill, then stream with s_valid=m_ready=1 for 40 cycles -> pointers wrap twice, output order equals input order, count is constant.
REQ-044 SHALL cover: m_valid=1 with m_ready held low for 5 cycles -> m_data is unchanged and ram_r_en=0 throughout.
REQ-045 SHALL cover: flush (and separately rst) asserted with count=9 and a read in flight -> next cycle count=0, m_valid=0; a following push returns data 2 cycles later.
